// File: rtl/recon_tx_framer.sv
// recon_tx_framer: frames a DMA read-back stream into one packet laid out as
// [46-byte template][10-byte recon header][payload shifted up by 56 bytes].
// Ports: clk/rst (sync active-high); hdr_template; s_cmd_* command in;
// m_axis_read_desc_* DMA read descriptor out; s_axis_* DMA data in;
// m_axis_* framed packet out; err_len length-mismatch pulse.
// Optional macro RECON_TX_LEN_CHECK_EN enables the payload byte counter behind err_len.
module recon_tx_framer #(
    parameter int DATA_WIDTH         = 512,
    parameter int KEEP_WIDTH         = DATA_WIDTH/8,
    parameter int ADDR_WIDTH         = 34,
    parameter int DMA_DESC_LEN_WIDTH = 20,
    parameter int DMA_DESC_TAG_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [375:0]                  hdr_template,
    input  logic                          s_cmd_valid,
    output logic                          s_cmd_ready,
    input  logic [1:0]                    s_cmd_func,
    input  logic [ADDR_WIDTH-1:0]         s_cmd_addr,
    input  logic [7:0]                    s_cmd_id,
    input  logic [31:0]                   s_cmd_len,
    output logic [ADDR_WIDTH-1:0]         m_axis_read_desc_addr,
    output logic [DMA_DESC_LEN_WIDTH-1:0] m_axis_read_desc_len,
    output logic [DMA_DESC_TAG_WIDTH-1:0] m_axis_read_desc_tag,
    output logic                          m_axis_read_desc_valid,
    input  logic                          m_axis_read_desc_ready,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    output logic                          s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic                          err_len
);
    typedef enum logic [2:0] {IDLE, DESC, HDR, PAYLOAD, FLUSH} state_t;
    state_t state, state_n;
    logic [1:0]              func_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              id_q;
    logic [31:0]             len_q;
    logic [367:0]            tmpl_q;
    logic [DATA_WIDTH-65:0]  residue;
    logic [KEEP_WIDTH-9:0]   residue_keep;
    logic [447:0]            head, base_data;
    logic [KEEP_WIDTH-9:0]   base_keep;
    logic [DATA_WIDTH-1:0]   out_data;
    logic [KEEP_WIDTH-1:0]   out_keep;
    logic adv, cmd_fire, in_fire, out_load, out_last, len_zero, keep_hi_zero, short_beat;
    logic unused_tmpl;
    // template bytes beyond 45 carry nothing into the packet
    assign unused_tmpl  = ^hdr_template[375:368];
    assign adv          = !m_axis_tvalid || m_axis_tready;
    assign cmd_fire     = s_cmd_valid && s_cmd_ready;
    assign in_fire      = s_axis_tvalid && s_axis_tready;
    assign len_zero     = len_q == '0;
    assign keep_hi_zero = s_axis_tkeep[KEEP_WIDTH-1:8] == '0;
    assign m_axis_read_desc_addr = addr_q;
    assign m_axis_read_desc_len  = len_q[DMA_DESC_LEN_WIDTH-1:0];
    assign m_axis_read_desc_tag  = DMA_DESC_TAG_WIDTH'(id_q);
    // short beats (empty-payload header, flush) carry no input bytes in the top 8 lanes
    assign short_beat = state == FLUSH || (state == HDR && len_zero);
    assign head       = {3'b000, len_q, id_q, 34'(addr_q), 1'b1, func_q, tmpl_q};
    assign base_data  = state == HDR ? head : residue;
    assign base_keep  = state == HDR ? '1 : residue_keep;
    assign out_data   = short_beat ? {64'b0, base_data} : {s_axis_tdata[63:0], base_data};
    assign out_keep   = short_beat ? {8'h00, base_keep} : {s_axis_tkeep[7:0], base_keep};
    assign out_last   = short_beat || (s_axis_tlast && keep_hi_zero);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n                = state;
        s_cmd_ready            = 1'b0;
        m_axis_read_desc_valid = 1'b0;
        s_axis_tready          = 1'b0;
        out_load               = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    s_cmd_ready = 1'b1;
                    if (s_cmd_valid) state_n = s_cmd_len == '0 ? HDR : DESC;
                end
                DESC: begin
                    m_axis_read_desc_valid = 1'b1;
                    if (m_axis_read_desc_ready) state_n = HDR;
                end
                HDR, PAYLOAD: begin
                    if (state == HDR && len_zero) begin
                        out_load = adv;
                        if (adv) state_n = IDLE;
                    end else begin
                        s_axis_tready = adv;
                        if (adv && s_axis_tvalid) begin
                            out_load = 1'b1;
                            state_n  = s_axis_tlast ? (keep_hi_zero ? IDLE : FLUSH) : PAYLOAD;
                        end
                    end
                end
                FLUSH: begin
                    out_load = adv;
                    if (adv) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            residue       <= '0;
            residue_keep  <= '0;
            func_q        <= '0;
            addr_q        <= '0;
            id_q          <= '0;
            len_q         <= '0;
            tmpl_q        <= '0;
        end else begin
            if (cmd_fire) begin
                func_q <= s_cmd_func;
                addr_q <= s_cmd_addr;
                id_q   <= s_cmd_id;
                len_q  <= s_cmd_len;
                tmpl_q <= hdr_template[367:0];
            end
            if (out_load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= out_data;
                m_axis_tkeep  <= out_keep;
                m_axis_tlast  <= out_last;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (in_fire) begin
                residue      <= s_axis_tdata[DATA_WIDTH-1:64];
                residue_keep <= s_axis_tkeep[KEEP_WIDTH-1:8];
            end
        end
    end

`ifdef RECON_TX_LEN_CHECK_EN
    logic [31:0] byte_cnt, cnt_total;
    logic        err_pend;
    assign cnt_total = byte_cnt + 32'($countones(s_axis_tkeep));
    // a mismatch found on a beat that needs a flush is held until the flush beat goes out
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= '0;
            err_pend <= 1'b0;
            err_len  <= 1'b0;
        end else begin
            err_len <= 1'b0;
            if (cmd_fire) byte_cnt <= '0;
            else if (in_fire) byte_cnt <= cnt_total;
            if (in_fire && s_axis_tlast) begin
                if (keep_hi_zero) err_len <= cnt_total != len_q;
                else              err_pend <= cnt_total != len_q;
            end
            if (state == FLUSH && out_load) begin
                err_len  <= err_pend;
                err_pend <= 1'b0;
            end
        end
    end
`else
    assign err_len = 1'b0;
`endif
endmodule

// File: tb/tb_recon_tx_framer.sv
// tb_recon_tx_framer: directed self-checking bench for recon_tx_framer
module tb_recon_tx_framer;
    localparam int DW = 512, KW = 64, AW = 34, LW = 20, TW = 8;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic [375:0]  hdr_template = '0;
    logic          s_cmd_valid = 1'b0, s_cmd_ready;
    logic [1:0]    s_cmd_func = '0;
    logic [AW-1:0] s_cmd_addr = '0;
    logic [7:0]    s_cmd_id = '0;
    logic [31:0]   s_cmd_len = '0;
    logic [AW-1:0] desc_addr;
    logic [LW-1:0] desc_len;
    logic [TW-1:0] desc_tag;
    logic          desc_valid, desc_ready = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic [KW-1:0] s_tkeep = '0;
    logic          s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tvalid, m_tlast, m_tready = 1'b1, err_len;

    recon_tx_framer dut (
        .clk(clk), .rst(rst), .hdr_template(hdr_template),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_func(s_cmd_func),
        .s_cmd_addr(s_cmd_addr), .s_cmd_id(s_cmd_id), .s_cmd_len(s_cmd_len),
        .m_axis_read_desc_addr(desc_addr), .m_axis_read_desc_len(desc_len),
        .m_axis_read_desc_tag(desc_tag), .m_axis_read_desc_valid(desc_valid),
        .m_axis_read_desc_ready(desc_ready),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast), .m_axis_tready(m_tready), .err_len(err_len)
    );

    int checks = 0, failures = 0;
    task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {logic [DW-1:0] d; logic [KW-1:0] k; logic l; logic e;} beat_t;
    beat_t         beats[$];
    logic [7:0]    pay[0:1023];
    logic [375:0]  tmpl_q;
    int            desc_cnt = 0, err_cnt = 0;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] d_len;
    logic [TW-1:0] d_tag;
    bit            stall = 1'b0, rnd = 1'b0;
    logic [639:0]  held;

    always @(negedge clk) begin
        if (rst) stall = 1'b0;
        else begin
            if (stall) check("stable", {62'b0, m_tvalid, m_tlast, m_tkeep, m_tdata}, held);
            if (err_len) err_cnt++;
            if (m_tvalid && m_tready) beats.push_back('{m_tdata, m_tkeep, m_tlast, err_len});
            if (desc_valid && desc_ready) begin
                desc_cnt++;
                d_addr = desc_addr;
                d_len  = desc_len;
                d_tag  = desc_tag;
            end
            stall = m_tvalid && !m_tready;
            held  = {62'b0, m_tvalid, m_tlast, m_tkeep, m_tdata};
        end
    end

    initial forever begin
        @(posedge clk); #1;
        m_tready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        desc_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic send_cmd(input logic [1:0] f, input logic [AW-1:0] a, input logic [7:0] id,
                            input logic [31:0] len);
        bit ok = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 47; i++) tmpl_q[i*8 +: 8] = 8'(i * 3 + int'(id));
        hdr_template = tmpl_q;
        s_cmd_valid = 1'b1; s_cmd_func = f; s_cmd_addr = a; s_cmd_id = id; s_cmd_len = len;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_cmd_ready) begin ok = 1'b1; break; end
        end
        check("cmd_accept", ok, 1);
        @(posedge clk); #1;
        s_cmd_valid = 1'b0;
        hdr_template = '1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input bit l);
        bit ok = 1'b0;
        s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (s_tready) begin ok = 1'b1; break; end
        end
        check("in_accept", ok, 1);
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
    endtask

    task automatic send_payload(input int n, input bit gaps);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        int nb = (n + 63) / 64;
        for (int b = 0; b < nb; b++) begin
            d = '0; k = '0;
            for (int j = 0; j < 64; j++)
                if (b * 64 + j < n) begin d[j*8 +: 8] = pay[b*64 + j]; k[j] = 1'b1; end
            send_beat(d, k, b == nb - 1);
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_last(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (beats.size() > 0 && beats[$].l) begin ok = 1'b1; break; end
        end
        check({nm, "_done"}, ok, 1);
    endtask

    task automatic check_pkt(input string nm, input logic [1:0] f, input logic [AW-1:0] a,
                             input logic [7:0] id, input logic [31:0] len, input int n);
        logic [447:0]  h = {3'b000, len, id, a, 1'b1, f, tmpl_q[367:0]};
        logic [DW-1:0] ed, mask;
        logic [KW-1:0] ek;
        int total = 56 + n;
        int nb = (total + 63) / 64;
        int idx;
        check({nm, "_beats"}, beats.size(), nb);
        for (int k = 0; k < nb && k < beats.size(); k++) begin
            ed = '0; ek = '0; mask = '0;
            for (int j = 0; j < 64; j++) begin
                idx = k * 64 + j;
                if (idx < total) begin
                    ek[j] = 1'b1;
                    mask[j*8 +: 8] = 8'hFF;
                    ed[j*8 +: 8] = idx < 56 ? h[idx*8 +: 8] : pay[idx - 56];
                end
            end
            check($sformatf("%s_keep%0d", nm, k), beats[k].k, ek);
            check($sformatf("%s_last%0d", nm, k), beats[k].l, k == nb - 1);
            check($sformatf("%s_data%0d", nm, k), beats[k].d & mask, ed);
        end
    endtask

    task automatic run_pkt(input string nm, input logic [1:0] f, input logic [AW-1:0] a,
                           input logic [7:0] id, input logic [31:0] len, input int n, input bit gaps);
        int dc = desc_cnt;
        beats.delete();
        send_cmd(f, a, id, len);
        if (n > 0) send_payload(n, gaps);
        wait_last(nm);
        check_pkt(nm, f, a, id, len, n);
        check({nm, "_desc"}, desc_cnt - dc, len != 0 ? 1 : 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) pay[i] = 8'(i * 13 + 5);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", s_cmd_ready, 0);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_desc_valid", desc_valid, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_err", err_len, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_pkt("len0", 2'd2, 34'h1_2345_6789, 8'h5A, 32'd0, 0, 1'b0);
        run_pkt("len8", 2'd1, 34'h0_0000_0040, 8'h11, 32'd8, 8, 1'b0);
        run_pkt("len64", 2'd3, 34'h2_0000_0000, 8'h22, 32'd64, 64, 1'b0);
        run_pkt("len200", 2'd0, 34'h3_0000_1000, 8'h33, 32'd200, 200, 1'b0);
        check("desc_addr", d_addr, 34'h3_0000_1000);
        check("desc_len", d_len, 20'd200);
        check("desc_tag", d_tag, 8'h33);

        rnd = 1'b1;
        run_pkt("len1000", 2'd1, 34'h0_1000_0000, 8'h44, 32'd1000, 1000, 1'b1);
        rnd = 1'b0;
        repeat (3) @(posedge clk); #1;

        run_pkt("short", 2'd2, 34'h0_0000_0200, 8'h55, 32'd100, 96, 1'b0);
`ifdef RECON_TX_LEN_CHECK_EN
        check("err_with_last", beats[$].e, 1);
        check("err_total", err_cnt, 1);
`else
        check("err_with_last", beats[$].e, 0);
        check("err_total", err_cnt, 0);
`endif

        beats.delete();
        send_cmd(2'd0, 34'h100, 8'h77, 32'd200);
        send_beat({DW{1'b1}}, {KW{1'b1}}, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_s_tready", s_tready, 0);
        check("mid_rst_cmd_ready", s_cmd_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_rst_tvalid", m_tvalid, 0);
        check("mid_rst_desc", desc_valid, 0);
        check("mid_rst_nolast", beats.size() > 0 ? beats[$].l : 1'b0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_pkt("after_rst", 2'd3, 34'h0_0000_0800, 8'h66, 32'd70, 70, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
